// File: rtl/constants.sv
// Shared assembler constants: ASCII codes, pass enum and framer state encoding.
// Imported by the source framer and its byte classifier.
package constants;

    typedef enum logic {
        PC_MAPPING = 1'b0,
        ASSEMBLING = 1'b1
    } assembler_state;

    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] TAB   = 8'h09;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] HASH  = 8'h23;
    localparam logic [7:0] EOT   = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD       = 3'd1,
        ST_BODY       = 3'd2,
        ST_SPACE_PEND = 3'd3,
        ST_COMMENT    = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } framer_state_t;

    typedef struct packed {
        logic printable;
        logic space;
        logic cr;
        logic eol;
        logic comment;
        logic eot;
        logic illegal;
    } char_class_t;

endpackage

// File: rtl/char_classifier.sv
// Combinational one-hot decode of a source byte into framer character classes.
// CR gets its own class because it is dropped without starting a space run.
module char_classifier
    import constants::*;
(
    input  logic [7:0]  ch,
    output char_class_t cls
);

    always_comb begin
        cls = '0;
        if (ch == SPACE || ch == TAB) begin
            cls.space = 1'b1;
        end else if (ch == CR) begin
            cls.cr = 1'b1;
        end else if (ch == LF) begin
            cls.eol = 1'b1;
        end else if (ch == HASH) begin
            cls.comment = 1'b1;
        end else if (ch == EOT) begin
            cls.eot = 1'b1;
        end else if (ch >= 8'h21 && ch <= 8'h7E) begin
            cls.printable = 1'b1;
        end else begin
            cls.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/source_framer.sv
// Normalises a raw ASCII byte stream into per-character / per-line pulses
// with comment stripping, whitespace collapsing and line/program limits.
module source_framer
    import constants::*;
#(
    parameter int NUMBER_LINES   = 256,
    parameter int MAX_LINE_CHARS = 32
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            pass_start,
    input  logic [7:0]                      byte_in,
    input  logic                            byte_valid_in,
    output logic                            byte_ready_out,
    input  logic                            hold_in,
    output logic [7:0]                      incoming_character,
    output logic                            new_character,
    output logic                            new_line,
    output logic                            valid_data,
    output logic [$clog2(NUMBER_LINES)-1:0] pc,
    output logic                            done_flag,
    output logic                            error_flag
);

    localparam int PCW = $clog2(NUMBER_LINES);
    localparam int CW  = $clog2(MAX_LINE_CHARS + 1);

    framer_state_t state, state_n;
    char_class_t   cls;

    logic [PCW-1:0] pc_q;
    logic [CW-1:0]  line_cnt_q;
    logic           defer_valid_q;
    logic [7:0]     defer_q;
    logic           full_q;
    logic           inc_pend_q;

    logic           accept;
    logic           emit;
    logic [7:0]     emit_ch;
    logic           eol;
    logic           defer_set;
    logic           defer_clr;
    logic           streaming_n;

    char_classifier u_cls (
        .ch  (byte_in),
        .cls (cls)
    );

    always_comb begin
        byte_ready_out = 1'b0;
        if (!pass_start && !hold_in && !defer_valid_q) begin
            byte_ready_out = (state == ST_LEAD) || (state == ST_BODY) ||
                             (state == ST_SPACE_PEND) || (state == ST_COMMENT);
        end
    end

    assign accept = byte_valid_in && byte_ready_out;

    always_comb begin
        state_n   = state;
        emit      = 1'b0;
        emit_ch   = 8'h00;
        eol       = 1'b0;
        defer_set = 1'b0;
        defer_clr = 1'b0;
        if (defer_valid_q) begin
            if (!hold_in) begin
                emit      = 1'b1;
                emit_ch   = defer_q;
                defer_clr = 1'b1;
            end
        end else if (accept) begin
            unique case (state)
                ST_LEAD: begin
                    unique case (1'b1)
                        cls.printable: begin
                            emit    = 1'b1;
                            emit_ch = byte_in;
                            state_n = ST_BODY;
                        end
                        cls.comment: state_n = ST_COMMENT;
                        cls.eot:     state_n = ST_DONE;
                        cls.illegal: state_n = ST_ERROR;
                        default: ;
                    endcase
                end
                ST_BODY, ST_SPACE_PEND: begin
                    unique case (1'b1)
                        cls.printable: begin
                            emit    = 1'b1;
                            state_n = ST_BODY;
                            if (state == ST_SPACE_PEND) begin
                                emit_ch   = SPACE;
                                defer_set = 1'b1;
                            end else begin
                                emit_ch = byte_in;
                            end
                        end
                        cls.space:   state_n = ST_SPACE_PEND;
                        cls.comment: state_n = ST_COMMENT;
                        cls.eol: begin
                            eol     = 1'b1;
                            state_n = ST_LEAD;
                        end
                        cls.eot: begin
                            eol     = 1'b1;
                            state_n = ST_DONE;
                        end
                        cls.illegal: state_n = ST_ERROR;
                        default: ;
                    endcase
                end
                ST_COMMENT: begin
                    if (cls.eol || cls.eot) begin
                        eol     = (line_cnt_q != '0);
                        state_n = cls.eot ? ST_DONE : ST_LEAD;
                    end
                end
                default: ;
            endcase
        end
        // Both limits reject the emission itself, before anything is pulsed
        if (emit && (line_cnt_q == CW'(MAX_LINE_CHARS) || full_q)) begin
            emit      = 1'b0;
            defer_set = 1'b0;
            defer_clr = 1'b1;
            state_n   = ST_ERROR;
        end
    end

    assign streaming_n = (state_n == ST_LEAD) || (state_n == ST_BODY) ||
                         (state_n == ST_SPACE_PEND) || (state_n == ST_COMMENT);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state              <= ST_IDLE;
            pc_q               <= '0;
            line_cnt_q         <= '0;
            defer_valid_q      <= 1'b0;
            defer_q            <= 8'h00;
            full_q             <= 1'b0;
            inc_pend_q         <= 1'b0;
            incoming_character <= 8'h00;
            new_character      <= 1'b0;
            new_line           <= 1'b0;
            valid_data         <= 1'b0;
            done_flag          <= 1'b0;
            error_flag         <= 1'b0;
        end else if (pass_start) begin
            state              <= ST_LEAD;
            pc_q               <= '0;
            line_cnt_q         <= '0;
            defer_valid_q      <= 1'b0;
            defer_q            <= 8'h00;
            full_q             <= 1'b0;
            inc_pend_q         <= 1'b0;
            incoming_character <= 8'h00;
            new_character      <= 1'b0;
            new_line           <= 1'b0;
            valid_data         <= 1'b1;
            done_flag          <= 1'b0;
            error_flag         <= 1'b0;
        end else begin
            state              <= state_n;
            new_character      <= emit;
            incoming_character <= emit ? emit_ch : 8'h00;
            new_line           <= eol;
            valid_data         <= streaming_n;
            done_flag          <= (state_n == ST_DONE) && (state != ST_DONE);
            error_flag         <= error_flag || (state_n == ST_ERROR);
            if (eol) begin
                line_cnt_q <= '0;
            end else if (emit) begin
                line_cnt_q <= line_cnt_q + CW'(1);
            end
            if (defer_set) begin
                defer_valid_q <= 1'b1;
                defer_q       <= byte_in;
            end else if (defer_clr) begin
                defer_valid_q <= 1'b0;
            end
            // Last line slot: hold pc and arm overflow for the next emission
            inc_pend_q <= eol && (pc_q != PCW'(NUMBER_LINES - 1));
            full_q     <= full_q || (eol && (pc_q == PCW'(NUMBER_LINES - 1)));
            if (inc_pend_q) begin
                pc_q <= pc_q + PCW'(1);
            end
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_source_framer.sv
// Directed bench for source_framer with NUMBER_LINES=4, MAX_LINE_CHARS=32.
// Emissions are collected by a negedge monitor and compared to hand values.
module tb_source_framer;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       pass_start;
    logic [7:0] byte_in;
    logic       byte_valid_in;
    logic       byte_ready_out;
    logic       hold_in;
    logic [7:0] incoming_character;
    logic       new_character;
    logic       new_line;
    logic       valid_data;
    logic [1:0] pc;
    logic       done_flag;
    logic       error_flag;

    int checks   = 0;
    int failures = 0;

    logic [7:0] chq[$];
    int nl_cnt   = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int tmp;

    always #5 clk_in = ~clk_in;

    source_framer #(
        .NUMBER_LINES   (4),
        .MAX_LINE_CHARS (32)
    ) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .pass_start         (pass_start),
        .byte_in            (byte_in),
        .byte_valid_in      (byte_valid_in),
        .byte_ready_out     (byte_ready_out),
        .hold_in            (hold_in),
        .incoming_character (incoming_character),
        .new_character      (new_character),
        .new_line           (new_line),
        .valid_data         (valid_data),
        .pc                 (pc),
        .done_flag          (done_flag),
        .error_flag         (error_flag)
    );

    always @(negedge clk_in) begin
        if (new_character) chq.push_back(incoming_character);
        if (new_line) nl_cnt++;
        if (done_flag) done_cnt++;
        if (new_character && new_line) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic clear_mon();
        chq.delete();
        nl_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        byte_in       = b;
        byte_valid_in = 1'b1;
        k = 0;
        @(negedge clk_in);
        while (!byte_ready_out && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= 50) chk("send_timeout", 32'(k), 32'd0);
        @(posedge clk_in);
        #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic pulse_start();
        pass_start = 1'b1;
        @(posedge clk_in);
        #1;
        pass_start = 1'b0;
    endtask

    task automatic chk_chars(input string tag, input string exp);
        chk({tag, "_count"}, 32'(chq.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < chq.size(); i++)
            chk($sformatf("%s_ch%0d", tag, i), 32'(chq[i]), 32'(exp[i]));
    endtask

    initial begin
        rst_n_in      = 1'b0;
        pass_start    = 1'b0;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        hold_in       = 1'b0;
        idle(3);
        @(negedge clk_in);
        chk("rst_ready", 32'(byte_ready_out), 32'd0);
        chk("rst_newc", 32'(new_character), 32'd0);
        chk("rst_valid", 32'(valid_data), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_err", 32'(error_flag), 32'd0);
        chk("rst_done", 32'(done_flag), 32'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        idle(1);

        // add line with leading blanks and one internal space
        pulse_start();
        chk("t1_valid", 32'(valid_data), 32'd1);
        clear_mon();
        send_str("  add x1");
        send(8'h0A);
        @(negedge clk_in);
        chk("t1_nl_pulse", 32'(new_line), 32'd1);
        chk("t1_nl_no_char", 32'(new_character), 32'd0);
        chk("t1_pc_at_nl", 32'(pc), 32'd0);
        @(negedge clk_in);
        chk("t1_pc_after", 32'(pc), 32'd1);
        idle(2);
        chk_chars("t1", "add x1");
        chk("t1_nl_cnt", 32'(nl_cnt), 32'd1);

        // blank lines, CR, comment-only line, trailing comment
        pulse_start();
        clear_mon();
        send_str("\n\r\n# c\nnop # x\n");
        idle(3);
        chk_chars("t2", "nop");
        chk("t2_nl_cnt", 32'(nl_cnt), 32'd1);
        chk("t2_pc", 32'(pc), 32'd1);

        // hold mid-stream, collapsed whitespace, EOT end
        pulse_start();
        clear_mon();
        send("a");
        hold_in = 1'b1;
        tmp = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (byte_ready_out) tmp++;
        end
        chk("t3_hold_ready", 32'(tmp), 32'd0);
        @(posedge clk_in);
        #1;
        hold_in = 1'b0;
        send(" ");
        send(8'h09);
        send(" ");
        send("b");
        @(negedge clk_in);
        chk("t3_split_ready", 32'(byte_ready_out), 32'd0);
        @(posedge clk_in);
        #1;
        send(8'h04);
        idle(4);
        chk_chars("t3", "a b");
        chk("t3_nl_cnt", 32'(nl_cnt), 32'd1);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        chk("t3_valid_off", 32'(valid_data), 32'd0);
        chk("t3_err", 32'(error_flag), 32'd0);

        // 33 characters on one line overflows the 32-char limit
        pulse_start();
        clear_mon();
        for (int i = 0; i < 33; i++) send(8'h61 + 8'(i % 26));
        idle(3);
        chk("t4_count", 32'(chq.size()), 32'd32);
        if (chq.size() > 0) chk("t4_last", 32'(chq[chq.size()-1]), 32'h66);
        chk("t4_err", 32'(error_flag), 32'd1);
        chk("t4_valid", 32'(valid_data), 32'd0);
        chk("t4_ready", 32'(byte_ready_out), 32'd0);
        pulse_start();
        chk("t4_err_clr", 32'(error_flag), 32'd0);
        chk("t4_valid_on", 32'(valid_data), 32'd1);

        // five non-empty lines into a 4-line program
        clear_mon();
        send_str("a\nb\nc\nd\n");
        idle(3);
        chk("t5_pc_full", 32'(pc), 32'd3);
        chk("t5_err_before", 32'(error_flag), 32'd0);
        send("e");
        idle(3);
        chk_chars("t5", "abcd");
        chk("t5_nl_cnt", 32'(nl_cnt), 32'd4);
        chk("t5_err", 32'(error_flag), 32'd1);
        chk("t5_pc_held", 32'(pc), 32'd3);

        // pass_start beats a simultaneous byte; then reset mid-line
        pass_start    = 1'b1;
        byte_in       = "z";
        byte_valid_in = 1'b1;
        @(negedge clk_in);
        chk("t6_start_wins", 32'(byte_ready_out), 32'd0);
        @(posedge clk_in);
        #1;
        pass_start    = 1'b0;
        byte_valid_in = 1'b0;
        clear_mon();
        send_str("q\nxy");
        idle(1);
        chk("t6_pc_pre", 32'(pc), 32'd1);
        chk_chars("t6_pre", "qxy");
        rst_n_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("t6_rst_pc", 32'(pc), 32'd0);
        chk("t6_rst_valid", 32'(valid_data), 32'd0);
        chk("t6_rst_ready", 32'(byte_ready_out), 32'd0);
        chk("t6_rst_newc", 32'(new_character), 32'd0);
        chk("t6_rst_char", 32'(incoming_character), 32'd0);
        chk("t6_rst_nl", 32'(new_line), 32'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        idle(1);
        clear_mon();
        pulse_start();
        send_str("hi\n");
        idle(3);
        chk_chars("t6", "hi");
        chk("t6_nl_cnt", 32'(nl_cnt), 32'd1);
        chk("t6_pc", 32'(pc), 32'd1);

        chk("nc_nl_exclusive", 32'(both_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
